// File: rtl/booth_mul_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   DEFAULT_WIDTH : default operand width in bits
//   ST_IDLE/ST_CALC/ST_DONE : FSM state encodings
package booth_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // FSM state encodings (IDLE, CALC, DONE)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_addsub.sv
// Ripple-style adder used for the Booth add/subtract step.
// Subtraction is done by the caller presenting ~b with Cin=1.
//   a, b     : WIDTH-bit operands
//   Cin      : carry in
//   S        : WIDTH-bit sum
//   Cout     : carry out of the MSB
//   Overflow : two's-complement overflow of S
module booth_addsub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);

  assign {Cout, S} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Cin};

  // Signed overflow: operands agree in sign but the sum does not.
  assign Overflow = (a[WIDTH-1] == b[WIDTH-1]) && (S[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock in CALC.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   start : begin a multiply (accepted in IDLE or DONE, ignored in CALC)
//   A, B  : signed multiplicand / multiplier, captured on acceptance
//   busy  : high while in CALC
//   done  : one-cycle pulse in DONE; P was updated on the edge entering DONE
//   P     : signed 2*WIDTH product, held until the next done
module booth_multiplier_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m;      // multiplicand
  logic [WIDTH:0]   r_acc;    // accumulator, one guard bit for -MIN
  logic [WIDTH-1:0] r_q;      // multiplier, shifts out LSB-first
  logic             r_qm1;    // Booth bit q(-1)
  logic [2*WIDTH-1:0] r_p;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_addsub_b;
  logic [WIDTH:0]   w_sum;
  logic             w_sub;
  logic             w_do_op;
  logic [WIDTH:0]   w_acc_op;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_cout;
  logic             w_ovf;
  logic             w_unused_flags;

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        w_last = (r_cnt == LAST_STEP);
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Booth recoding of (q0, q-1): 01 -> +M, 10 -> -M, else nothing.
  assign w_sub      = r_q[0] & ~r_qm1;
  assign w_do_op    = r_q[0] ^ r_qm1;
  assign w_m_ext    = {r_m[WIDTH-1], r_m};
  assign w_addsub_b = w_sub ? ~w_m_ext : w_m_ext;

  booth_addsub #(
    .WIDTH (WIDTH + 1)
  ) u_addsub (
    .a        (r_acc),
    .b        (w_addsub_b),
    .Cin      (w_sub),
    .S        (w_sum),
    .Cout     (w_cout),
    .Overflow (w_ovf)
  );

  // Carry/overflow are not needed: the guard bit makes the sum exact.
  assign w_unused_flags = w_cout ^ w_ovf;

  assign w_acc_op  = w_do_op ? w_sum : r_acc;

  // Arithmetic shift right of {acc, q, q-1}
  assign w_acc_nxt = {w_acc_op[WIDTH], w_acc_op[WIDTH:1]};
  assign w_q_nxt   = {w_acc_op[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_m   <= A;
        r_q   <= B;
        r_acc <= '0;
        r_qm1 <= 1'b0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_qm1 <= r_q[0];
        r_cnt <= r_cnt + 1'b1;
        // Publish only the final product, on the edge entering DONE.
        if (w_last) begin
          r_p <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
        end
      end
    end
  end

  assign busy = (r_state == ST_CALC);
  assign done = (r_state == ST_DONE);
  assign P    = r_p;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  logic [2*W-1:0] exp_q[$];

  booth_multiplier_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops and compares one expected product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b expected busy=0", busy, done);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: P=%h with no product pending", P);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (P !== e) begin
          errors++;
          $display("FAIL product: got %h expected %h", P, e);
        end
      end
    end
  end

  // Drive a start for one edge; return just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    exp_q.push_back(ref_mul(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Count negedges until done; lat=0 on timeout.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    for (int i = 1; i <= W + 8; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", W + 8);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int nd0;
    logic [W-1:0] corners [5];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    corners = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_P", P, 64'd0);

    // Release at a negedge with start already high: first edge must accept.
    start = 1'b1;
    A     = 32'd7;
    B     = 32'hFFFF_FFFD;
    rst_n = 1'b1;
    issue(32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bc);
    check("latency_7x-3", 64'(lat), 64'(W + 1));
    check("busy_cycles_7x-3", 64'(bc), 64'(W));
    check("P_7x-3_direct", P, 64'hFFFF_FFFF_FFFF_FFEB);

    @(negedge clk);
    issue(32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bc);
    check("P_min_x_min", P, 64'h4000_0000_0000_0000);
    @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check("P_min_x_m1", P, 64'h0000_0000_8000_0000);

    // Zero, then back-to-back start held in the DONE cycle.
    @(negedge clk);
    issue(32'd0, 32'h7FFF_FFFF);
    wait_done(lat, bc);
    start = 1'b1;
    A     = 32'd100;
    B     = 32'd50;
    exp_q.push_back(64'd5000);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_P_held", P, 64'd0);
    wait_done(lat, bc);
    check("b2b_busy_cycles", 64'(bc), 64'(W - 1));

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    nd0 = n_done;
    issue(32'hFFFF_FFF6, 32'hFFFF_FFF8);
    repeat (5) @(negedge clk);
    start = 1'b1;
    A     = 32'd1;
    B     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    repeat (6) @(negedge clk);
    check("busy_start_P", P, 64'd80);
    check("busy_start_one_done", 64'(n_done - nd0), 64'd1);

    // Reset in the middle of CALC abandons the multiply.
    nd0 = n_done;
    issue(32'd5, 32'd5);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_P", P, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("midrst_no_done", 64'(n_done - nd0), 64'd0);
    issue(32'd5, 32'd5);
    wait_done(lat, bc);
    check("after_rst_P", P, 64'd25);

    // Randomized products with occasional corner operands.
    for (int k = 0; k < 1000; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      @(negedge clk);
      issue(ra, rb);
      wait_done(lat, bc);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_products: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
